mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported synchronous memory between the fetch stage (instruction reads) and the execute/memory stage (data reads/writes) of the pipelined core.
- Grants at most one access per cycle and stalls the losing requester.
- Routes the 1-cycle-latency read data back to the owner.
- Squashes in-flight fetch responses on a pipeline flush (branch miss, interrupt, return).

Parameters:
ADDR_W, 10, memory address width
DATA_W, 18, memory data width (instruction and data words)
MAX_WAIT, 3, consecutive fetch losses before fetch is forced to win (fairness feature only)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
if_req  in  1  fetch read request; held stable while if_stall=1
if_addr  in  ADDR_W  fetch address
if_rdata  out  DATA_W  fetch read data, meaningful when if_valid=1
if_valid  out  1  one-cycle pulse: fetch read data returned
if_stall  out  1  fetch request present but not granted this cycle
ex_req  in  1  data request; held stable while ex_stall=1
ex_we  in  1  1=write, 0=read
ex_addr  in  ADDR_W  data address
ex_wdata  in  DATA_W  write data
ex_rdata  out  DATA_W  data read data, meaningful when ex_valid=1
ex_valid  out  1  one-cycle pulse: data read returned
ex_stall  out  1  data request present but not granted this cycle
flush  in  1  pipeline flush: cancel and squash fetch traffic
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid the cycle after a read with mem_en=1

Behaviour:
- Grant logic is combinational on the current-cycle inputs and registered state.
- Priority: the data request wins over the fetch request. Fetch is granted only when if_req=1, ex_req=0 and flush=0.
- ex_grant = ex_req. if_grant = if_req & !ex_req & !flush.
- Stall outputs: ex_stall = 0 (except under the fairness override). if_stall = if_req & !if_grant.
- Memory drive:
  - mem_en = ex_grant | if_grant.
  - mem_we = ex_grant & ex_we.
  - mem_addr and mem_wdata come from the granted requester.
  - When idle: mem_en=0, mem_we=0, address and data 0.
- Response tracking uses registers resp_if and resp_ex, updated every cycle:
  - resp_if <= if_grant.
  - resp_ex <= ex_grant & !ex_we.
- Responses:
  - if_valid = resp_if & !flush.
  - ex_valid = resp_ex.
  - if_rdata and ex_rdata both present mem_rdata; consumers qualify them with their valid.
- Writes generate no valid pulse. A write is accepted in the cycle ex_stall=0.
- Back-to-back grants are allowed every cycle, giving full throughput with no bubble.
- Flush:
  - Blocks any fetch grant in the flush cycle (if_stall=1 if if_req=1).
  - Forces if_valid=0 in that cycle.
  - Does not affect data traffic.
- Reset: resp_if=resp_ex=0, wait counter=0, and all outputs 0 (mem_en, mem_we, if_valid, ex_valid, if_stall, ex_stall). A response pending when reset asserts is dropped and no valid pulse follows.
- Requests with req=0 are ignored regardless of address and data values.

Optional Feature:
ARB_FAIRNESS_EN:
- Defined:
  - A wait counter ($clog2(MAX_WAIT+1) bits, saturating) increments each cycle if_stall=1 due to ex_req (not flush).
  - The counter clears on any fetch grant, on flush, or when if_req=0.
  - When the counter equals MAX_WAIT and if_req & !flush, fetch wins: if_grant=1, ex_grant=0, ex_stall=ex_req.
  - The counter clears the following cycle.
- Undefined: strict data priority; no counter logic; ex_stall is constant 0.

Test Plan:
- Reset then idle: hold reset 2 cycles with if_req=ex_req=1 -> all outputs 0 during reset; one cycle after release mem_en=1 with ex_addr.
- Fetch only: if_req=1, if_addr=0x010, mem_rdata=0x2ABCD next cycle -> mem_en=1, mem_we=0, mem_addr=0x010; next cycle if_valid=1, if_rdata=0x2ABCD; if_stall=0 throughout.
- Contention: if_req=ex_req=1, ex_we=0, ex_addr=0x3FF for 1 cycle, then ex_req=0 -> cycle0: mem_addr=0x3FF, if_stall=1; cycle1: ex_valid=1, mem_addr=if_addr; cycle2: if_valid=1.
- Write: ex_req=1, ex_we=1, ex_addr=0x005, ex_wdata=0x00042 -> mem_we=1, mem_wdata=0x00042; next cycle ex_valid=0.
- Flush squash: fetch granted at cycle0, flush=1 at cycle1 with if_req=1 -> if_valid=0 at cycle1, no fetch grant at cycle1; if_valid=1 at cycle3 after regrant at cycle2.
- Fairness (ARB_FAIRNESS_EN, MAX_WAIT=3): if_req=ex_req=1 continuously -> data wins cycles 0-2, fetch wins cycle 3 with ex_stall=1, data wins cycles 4-6, pattern repeats; without the macro fetch never wins.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported synchronous memory between fetch reads and execute reads/writes.
// Data side has priority; define ARB_FAIRNESS_EN to force a fetch grant after MAX_WAIT consecutive losses.
module mem_port_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 18,
  parameter int MAX_WAIT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              ex_req,
  input  logic              ex_we,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_wdata,
  output logic [DATA_W-1:0] ex_rdata,
  output logic              ex_valid,
  output logic              ex_stall,
  input  logic              flush,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic resp_if_q, resp_if_d;
  logic resp_ex_q, resp_ex_d;
  logic if_grant, ex_grant;
  logic force_if;

`ifdef ARB_FAIRNESS_EN
  localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] wait_q, wait_d;

  assign force_if = !reset && if_req && !flush && (wait_q == CNT_W'(MAX_WAIT));

  // Counts only losses to the data side; a flush or idle fetch restarts the count.
  always_comb begin
    wait_d = wait_q;
    if (if_grant || flush || !if_req) begin
      wait_d = '0;
    end else if (ex_req && (wait_q != CNT_W'(MAX_WAIT))) begin
      wait_d = wait_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end
`else
  assign force_if = 1'b0;
`endif

  always_comb begin
    ex_grant  = !reset && ex_req && !force_if;
    if_grant  = !reset && (force_if || (if_req && !ex_req && !flush));
    ex_stall  = ex_req && force_if;
    if_stall  = !reset && if_req && !if_grant;

    mem_en    = ex_grant || if_grant;
    mem_we    = ex_grant && ex_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (ex_grant) begin
      mem_addr  = ex_addr;
      mem_wdata = ex_wdata;
    end else if (if_grant) begin
      mem_addr  = if_addr;
    end

    resp_if_d = if_grant;
    resp_ex_d = ex_grant && !ex_we;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_if_q <= 1'b0;
      resp_ex_q <= 1'b0;
    end else begin
      resp_if_q <= resp_if_d;
      resp_ex_q <= resp_ex_d;
    end
  end

  // Reset also masks a response that was in flight when reset arrived.
  assign if_valid = resp_if_q && !flush && !reset;
  assign ex_valid = resp_ex_q && !reset;
  assign if_rdata = mem_rdata;
  assign ex_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter with a transaction-level reference model and a memory device.
module tb_mem_port_arbiter;
  localparam int AW = 10;
  localparam int DW = 18;
  localparam int MAX_WAIT = 3;
`ifdef ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, if_req, ex_req, ex_we, flush;
  logic [AW-1:0] if_addr, ex_addr, mem_addr;
  logic [DW-1:0] ex_wdata, if_rdata, ex_rdata, mem_wdata, mem_rdata;
  logic if_valid, if_stall, ex_valid, ex_stall, mem_en, mem_we;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
    .ex_req(ex_req), .ex_we(ex_we), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .ex_rdata(ex_rdata), .ex_valid(ex_valid), .ex_stall(ex_stall),
    .flush(flush),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory device attached to the arbiter's port
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  // Reference model state
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  bit            m_pif, m_pex;
  logic [DW-1:0] m_dif, m_dex;
  int            m_loss;
  bit            last_ifst, last_exst;
  bit            e_ig;
  int            checks = 0;
  int            errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit iq, input logic [AW-1:0] ia,
                      input bit eq, input bit ewe, input logic [AW-1:0] ea,
                      input logic [DW-1:0] ewd, input bit fl);
    bit frc, eg, ig, ev, iv;
    logic [AW-1:0] eaddr;
    @(negedge clk);
    reset = r; if_req = iq; if_addr = ia; ex_req = eq; ex_we = ewe;
    ex_addr = ea; ex_wdata = ewd; flush = fl;
    #1;
    frc = FAIR && !r && iq && !fl && (m_loss == MAX_WAIT);
    eg  = !r && eq && !frc;
    ig  = !r && (frc || (iq && !eq && !fl));
    iv  = !r && m_pif && !fl;
    ev  = !r && m_pex;
    eaddr = eg ? ea : (ig ? ia : '0);
    check("mem_en",    mem_en,    eg || ig);
    check("mem_we",    mem_we,    eg && ewe);
    check("mem_addr",  mem_addr,  eaddr);
    check("mem_wdata", mem_wdata, eg ? ewd : '0);
    check("if_stall",  if_stall,  !r && iq && !ig);
    check("ex_stall",  ex_stall,  !r && eq && !eg);
    check("if_valid",  if_valid,  iv);
    check("ex_valid",  ex_valid,  ev);
    if (iv) check("if_rdata", if_rdata, m_dif);
    if (ev) check("ex_rdata", ex_rdata, m_dex);
    e_ig = ig;
    // advance the model to the state after this clock edge
    if (r) begin
      m_pif = 0; m_pex = 0; m_loss = 0;
    end else begin
      m_pif = ig;
      if (ig) m_dif = ref_mem[ia];
      m_pex = eg && !ewe;
      if (eg && !ewe) m_dex = ref_mem[ea];
      if (eg && ewe) ref_mem[ea] = ewd;
      if (ig || fl || !iq) m_loss = 0;
      else if (eq && m_loss < MAX_WAIT) m_loss++;
    end
    last_ifst = !r && iq && !ig;
    last_exst = !r && eq && !eg;
  endtask

  initial begin
    bit iq, eq, ewe, fl, r;
    logic [AW-1:0] ia, ea;
    logic [DW-1:0] wd;
    logic [7:0] wins;
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i] = DW'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[10'h010] = 18'h2ABCD;
    ref_mem[10'h010] = 18'h2ABCD;
    m_pif = 0; m_pex = 0; m_loss = 0; m_dif = '0; m_dex = '0;
    last_ifst = 0; last_exst = 0;

    // Reset with both requesting: everything quiet
    step(1, 1, 10'h011, 1, 0, 10'h022, 18'h0, 0);
    check("rst_mem_en", mem_en, 0);
    step(1, 1, 10'h011, 1, 0, 10'h022, 18'h0, 0);
    check("rst_if_stall", if_stall, 0);
    step(0, 1, 10'h011, 1, 0, 10'h022, 18'h0, 0);
    check("post_rst_mem_en", mem_en, 1);
    check("post_rst_addr", mem_addr, 10'h022);
    step(0, 0, 10'h0, 0, 0, 10'h0, 18'h0, 0);

    // Fetch only
    step(0, 1, 10'h010, 0, 0, 10'h0, 18'h0, 0);
    check("fetch_addr", mem_addr, 10'h010);
    step(0, 0, 10'h0, 0, 0, 10'h0, 18'h0, 0);
    check("fetch_valid", if_valid, 1);
    check("fetch_rdata", if_rdata, 18'h2ABCD);

    // Contention then release
    step(0, 1, 10'h010, 1, 0, 10'h3FF, 18'h0, 0);
    check("cont_addr", mem_addr, 10'h3FF);
    check("cont_if_stall", if_stall, 1);
    step(0, 1, 10'h010, 0, 0, 10'h3FF, 18'h0, 0);
    check("cont_ex_valid", ex_valid, 1);
    check("cont_fetch_addr", mem_addr, 10'h010);
    step(0, 0, 10'h0, 0, 0, 10'h0, 18'h0, 0);
    check("cont_if_valid", if_valid, 1);

    // Write produces no response
    step(0, 0, 10'h0, 1, 1, 10'h005, 18'h00042, 0);
    check("wr_we", mem_we, 1);
    check("wr_wdata", mem_wdata, 18'h00042);
    step(0, 0, 10'h0, 0, 0, 10'h0, 18'h0, 0);
    check("wr_no_valid", ex_valid, 0);

    // Flush squashes an in-flight fetch and blocks regrant
    step(0, 1, 10'h010, 0, 0, 10'h0, 18'h0, 0);
    step(0, 1, 10'h020, 0, 0, 10'h0, 18'h0, 1);
    check("flush_if_valid", if_valid, 0);
    check("flush_no_grant", mem_en, 0);
    step(0, 1, 10'h020, 0, 0, 10'h0, 18'h0, 0);
    step(0, 0, 10'h0, 0, 0, 10'h0, 18'h0, 0);
    check("flush_regrant_valid", if_valid, 1);

    // Sustained contention: which cycles does fetch win
    wins = '0;
    for (int c = 0; c < 8; c++) begin
      step(0, 1, 10'h100, 1, 0, 10'h200, 18'h0, 0);
      wins[c] = (mem_addr == 10'h100);
    end
`ifdef ARB_FAIRNESS_EN
    check("fair_pattern", {24'h0, wins}, 32'h88);
`else
    check("fair_pattern", {24'h0, wins}, 32'h00);
`endif
    step(0, 0, 10'h0, 0, 0, 10'h0, 18'h0, 0);

    // Randomized traffic on a small address window to exercise read-after-write
    iq = 0; eq = 0; ewe = 0; ia = '0; ea = '0; wd = '0;
    for (int c = 0; c < 2000; c++) begin
      r  = ($urandom_range(0, 99) == 0);
      fl = ($urandom_range(0, 7) == 0);
      if (!last_ifst) begin
        iq = ($urandom_range(0, 2) != 0);
        ia = AW'($urandom_range(0, 15));
      end
      if (!last_exst) begin
        eq  = ($urandom_range(0, 1) != 0);
        ewe = ($urandom_range(0, 2) == 0);
        ea  = AW'($urandom_range(0, 15));
        wd  = DW'($urandom);
      end
      step(r, iq, ia, eq, ewe, ea, wd, fl);
    end
    if (e_ig) checks += 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
